// File: rtl/serial_pkg.sv
// Shared definitions for the asynchronous serial frame transmitter and its receiver counterpart.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_PARITY_EN = 1;
    localparam int DEFAULT_STOP_BITS = 1;

    // Bit periods per frame: start bit, data bits, optional parity bit, stop bits.
    function automatic int frame_bits(input int data_bits, input int parity_en, input int stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/bit_tick_detect.sv
// Rising-edge detector that turns the divided bit clock into a one-cycle tick on the system clock.
module bit_tick_detect (
    input  logic clock_in,
    input  logic reset,
    input  logic bit_clk,
    output logic tick
);

    logic r_bit_clk_q;

    // Clearing the history on reset means an already-high bit_clk yields one tick afterwards.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_bit_clk_q <= 1'b0;
        end else begin
            r_bit_clk_q <= bit_clk;
        end
    end

    assign tick = bit_clk & ~r_bit_clk_q;

endmodule

// File: rtl/serial_frame_tx.sv
// Serialises parallel words into start / LSB-first data / optional even parity / stop-bit frames,
// advancing one bit per rising edge of the divided bit clock.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int PARITY_EN = DEFAULT_PARITY_EN,
    parameter int STOP_BITS = DEFAULT_STOP_BITS
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 bit_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [3:0] LAST_IDX  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            r_state, w_next_state;
    logic [DATA_BITS-1:0] r_shift, w_next_shift;
    logic [3:0]           r_bit_idx, w_next_bit_idx;
    logic                 r_stop_cnt, w_next_stop_cnt;
    logic                 r_parity, w_next_parity;
    logic                 r_tx_out, w_next_tx_out;
    logic                 r_frame_done, w_next_frame_done;
    logic                 w_tick;

    bit_tick_detect u_tick_detect (
        .clock_in (clock_in),
        .reset    (reset),
        .bit_clk  (bit_clk),
        .tick     (w_tick)
    );

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_stop_cnt   <= 1'b0;
            r_parity     <= 1'b0;
            r_tx_out     <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_shift      <= w_next_shift;
            r_bit_idx    <= w_next_bit_idx;
            r_stop_cnt   <= w_next_stop_cnt;
            r_parity     <= w_next_parity;
            r_tx_out     <= w_next_tx_out;
            r_frame_done <= w_next_frame_done;
        end
    end

    // The line is registered so every bit edge lands on the clock edge that ends a tick cycle.
    always_comb begin
        w_next_state      = r_state;
        w_next_shift      = r_shift;
        w_next_bit_idx    = r_bit_idx;
        w_next_stop_cnt   = r_stop_cnt;
        w_next_parity     = r_parity;
        w_next_tx_out     = r_tx_out;
        w_next_frame_done = 1'b0;

        case (r_state)
            IDLE: begin
                w_next_tx_out = 1'b1;
                if (tx_valid) begin
                    w_next_shift  = tx_data;
                    w_next_parity = ^tx_data;
                    w_next_state  = ARMED;
                end
            end
            ARMED: begin
                if (w_tick) begin
                    w_next_tx_out = 1'b0;
                    w_next_state  = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_next_tx_out  = r_shift[0];
                    w_next_bit_idx = '0;
                    w_next_state   = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx != LAST_IDX) begin
                        w_next_shift   = r_shift >> 1;
                        w_next_tx_out  = r_shift[1];
                        w_next_bit_idx = r_bit_idx + 4'd1;
                    end else if (PARITY_EN != 0) begin
                        w_next_tx_out = r_parity;
                        w_next_state  = PARITY;
                    end else begin
                        w_next_tx_out   = 1'b1;
                        w_next_stop_cnt = 1'b0;
                        w_next_state    = STOP;
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_next_tx_out   = 1'b1;
                    w_next_stop_cnt = 1'b0;
                    w_next_state    = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_stop_cnt != LAST_STOP) begin
                        w_next_stop_cnt = r_stop_cnt + 1'b1;
                    end else begin
                        w_next_state      = IDLE;
                        w_next_frame_done = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign tx_ready   = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign tx_out     = r_tx_out;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: a default instance and a no-parity/two-stop instance,
// with the serial line compared cycle by cycle against a frame model built from the word.
module tb_serial_frame_tx;
    import serial_pkg::*;

    // A short divider keeps the run small; every check is expressed in units of BIT_PERIOD.
    localparam int HALF_BIT     = 8;
    localparam int BIT_PERIOD   = 2 * HALF_BIT;
    localparam int FRAME_A      = frame_bits(8, 1, 1);
    localparam int STALL_CYCLES = 125 * BIT_PERIOD;

    logic       clockIn     = 1'b0;
    logic       reset       = 1'b1;
    logic       bitClk      = 1'b0;
    logic       stallBitClk = 1'b0;
    logic [7:0] txDataA     = 8'h00;
    logic [7:0] txDataB     = 8'h00;
    logic       txValidA    = 1'b0;
    logic       txValidB    = 1'b0;
    logic       txReadyA, txOutA, busyA, frameDoneA;
    logic       txReadyB, txOutB, busyB, frameDoneB;
    logic       sel         = 1'b0;
    logic       obsTx, obsBusy, obsReady, obsDone;

    int checkCount = 0;
    int passCount  = 0;
    bit expBits[$];

    serial_frame_tx #(.DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1)) dutA (
        .clock_in   (clockIn),
        .reset      (reset),
        .bit_clk    (bitClk),
        .tx_data    (txDataA),
        .tx_valid   (txValidA),
        .tx_ready   (txReadyA),
        .tx_out     (txOutA),
        .busy       (busyA),
        .frame_done (frameDoneA)
    );

    serial_frame_tx #(.DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(2)) dutB (
        .clock_in   (clockIn),
        .reset      (reset),
        .bit_clk    (bitClk),
        .tx_data    (txDataB),
        .tx_valid   (txValidB),
        .tx_ready   (txReadyB),
        .tx_out     (txOutB),
        .busy       (busyB),
        .frame_done (frameDoneB)
    );

    assign obsTx    = sel ? txOutB     : txOutA;
    assign obsBusy  = sel ? busyB      : busyA;
    assign obsReady = sel ? txReadyB   : txReadyA;
    assign obsDone  = sel ? frameDoneB : frameDoneA;

    always #25 clockIn = ~clockIn;

    // Stalls are whole bit periods, so the divider phase is unchanged once it resumes.
    initial begin
        forever begin
            repeat (HALF_BIT) @(posedge clockIn);
            #1;
            if (!stallBitClk) bitClk = ~bitClk;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) passCount = passCount + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    function automatic void buildFrame(input logic [7:0] word, input int parityEn, input int stopBits);
        int ones;
        ones = 0;
        expBits.delete();
        expBits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            expBits.push_back(word[i]);
            if (word[i]) ones++;
        end
        if (parityEn != 0) expBits.push_back(bit'(ones % 2));
        for (int s = 0; s < stopBits; s++) expBits.push_back(1'b1);
    endfunction

    task automatic applyStimulus(input logic [7:0] word, input bit hold);
        checkOutput("ready before send", {31'd0, obsReady}, 32'd1);
        if (sel == 1'b0) begin
            txDataA  = word;
            txValidA = 1'b1;
        end else begin
            txDataB  = word;
            txValidB = 1'b1;
        end
        @(negedge clockIn);
        if (!hold) begin
            txValidA = 1'b0;
            txValidB = 1'b0;
            txDataA  = 8'($urandom);
            txDataB  = 8'($urandom);
        end
    endtask

    task automatic waitStart(input int limit, output int waited);
        waited = 0;
        while (obsTx !== 1'b0 && waited < limit) begin
            @(negedge clockIn);
            waited++;
        end
    endtask

    // Starts on the first sample of the start bit; returns on the sample where frame_done should be high.
    task automatic checkFrame(input string tag, input int stallBit);
        int matched;
        int pulses;
        pulses = 0;
        for (int i = 0; i < expBits.size(); i++) begin
            if (i == stallBit) begin
                matched = 0;
                stallBitClk = 1'b1;
                for (int c = 0; c < STALL_CYCLES; c++) begin
                    if (obsTx === expBits[i] && obsBusy === 1'b1) matched++;
                    if (obsDone === 1'b1) pulses++;
                    @(negedge clockIn);
                end
                stallBitClk = 1'b0;
                checkOutput($sformatf("%s stall hold bit %0d", tag, i), matched, STALL_CYCLES);
            end
            matched = 0;
            for (int c = 0; c < BIT_PERIOD; c++) begin
                if (obsTx === expBits[i] && obsBusy === 1'b1) matched++;
                if (obsDone === 1'b1) pulses++;
                @(negedge clockIn);
            end
            checkOutput($sformatf("%s bit %0d cycles", tag, i), matched, BIT_PERIOD);
        end
        checkOutput($sformatf("%s early frame_done", tag), pulses, 0);
        checkOutput($sformatf("%s frame_done at end", tag), {31'd0, obsDone}, 32'd1);
        checkOutput($sformatf("%s ready at end", tag), {31'd0, obsReady}, 32'd1);
        checkOutput($sformatf("%s busy at end", tag), {31'd0, obsBusy}, 32'd0);
        checkOutput($sformatf("%s idle line at end", tag), {31'd0, obsTx}, 32'd1);
    endtask

    task automatic sendAndCheck(input string tag, input logic [7:0] word, input int parityEn,
                                input int stopBits, input int stallBit);
        int waited;
        buildFrame(word, parityEn, stopBits);
        applyStimulus(word, 1'b0);
        waitStart(2 * BIT_PERIOD, waited);
        checkOutput($sformatf("%s start latency", tag), {31'd0, (waited <= BIT_PERIOD)}, 32'd1);
        checkFrame(tag, stallBit);
        @(negedge clockIn);
        checkOutput($sformatf("%s frame_done one cycle", tag), {31'd0, obsDone}, 32'd0);
    endtask

    initial begin
        int waited;
        int matched;
        int pulses;

        $display("[TB] reset and idle");
        repeat (3) @(negedge clockIn);
        reset = 1'b0;
        checkOutput("reset tx_out", {31'd0, obsTx}, 32'd1);
        checkOutput("reset busy", {31'd0, obsBusy}, 32'd0);
        checkOutput("reset tx_ready", {31'd0, obsReady}, 32'd1);
        checkOutput("reset frame_done", {31'd0, obsDone}, 32'd0);
        pulses = 0;
        matched = 0;
        repeat (5000) begin
            if (frameDoneA === 1'b1 || frameDoneB === 1'b1) pulses++;
            if (txOutA === 1'b1 && txOutB === 1'b1) matched++;
            @(negedge clockIn);
        end
        checkOutput("idle frame_done pulses", pulses, 0);
        checkOutput("idle line high cycles", matched, 5000);

        $display("[TB] single frame 0xA5");
        sendAndCheck("A5", 8'hA5, 1, 1, -1);

        $display("[TB] no parity, two stop bits");
        sel = 1'b1;
        sendAndCheck("noparity 01", 8'h01, 0, 2, -1);
        sel = 1'b0;

        $display("[TB] back-to-back");
        buildFrame(8'h00, 1, 1);
        applyStimulus(8'h00, 1'b1);
        txDataA = 8'hFF;
        waitStart(2 * BIT_PERIOD, waited);
        checkOutput("b2b first start latency", {31'd0, (waited <= BIT_PERIOD)}, 32'd1);
        checkFrame("b2b 00", -1);
        @(negedge clockIn);
        checkOutput("b2b ready single cycle", {31'd0, obsReady}, 32'd0);
        txValidA = 1'b0;
        txDataA  = 8'($urandom);
        buildFrame(8'hFF, 1, 1);
        waitStart(2 * BIT_PERIOD, waited);
        checkOutput("b2b second start on next tick", waited, BIT_PERIOD - 1);
        checkFrame("b2b FF", -1);
        @(negedge clockIn);

        $display("[TB] reset mid-frame");
        buildFrame(8'h3C, 1, 1);
        applyStimulus(8'h3C, 1'b0);
        waitStart(2 * BIT_PERIOD, waited);
        checkOutput("midreset start seen", {31'd0, obsTx}, 32'd0);
        repeat (4 * BIT_PERIOD + BIT_PERIOD / 2) @(negedge clockIn);
        checkOutput("midreset data bit 3", {31'd0, obsTx}, {31'd0, expBits[4]});
        reset = 1'b1;
        @(negedge clockIn);
        reset = 1'b0;
        checkOutput("midreset tx_out", {31'd0, obsTx}, 32'd1);
        checkOutput("midreset busy", {31'd0, obsBusy}, 32'd0);
        checkOutput("midreset tx_ready", {31'd0, obsReady}, 32'd1);
        matched = 0;
        repeat (3 * FRAME_A * BIT_PERIOD) begin
            if (obsTx === 1'b1 && obsDone === 1'b0 && obsBusy === 1'b0) matched++;
            @(negedge clockIn);
        end
        checkOutput("midreset quiet cycles", matched, 3 * FRAME_A * BIT_PERIOD);
        sendAndCheck("after reset", 8'h5A, 1, 1, -1);

        $display("[TB] stall during data");
        sendAndCheck("stall", 8'h96, 1, 1, 5);

        $display("[TB] random words");
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 40)) @(negedge clockIn);
            sendAndCheck($sformatf("randA%0d", k), 8'($urandom), 1, 1, -1);
        end
        sel = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 40)) @(negedge clockIn);
            sendAndCheck($sformatf("randB%0d", k), 8'($urandom), 0, 2, -1);
        end
        sel = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
